// File: rtl/priority_encoder_4to2_if.sv
// priority_encoder_4to2_if
// Bundles the request/grant signals of the 4-to-2 priority encoder.
//
// Handshake: the encoder raises valid with a stable index on y (and the
// multi flag) and holds all three unchanged until the consumer asserts ack.
// A grant completes on the rising edge where valid=1 and ack=1. ack while
// valid=0 has no effect. After a completed grant valid is low for at least
// one cycle before the next grant.
//
// Signals:
//   e     - capture enable for i (master -> encoder)
//   i     - 4 request lines (master -> encoder)
//   ack   - consumer accepts the current grant (master -> encoder)
//   y     - granted index (encoder -> master)
//   valid - y holds a live grant (encoder -> master)
//   multi - other requests were pending when the grant was loaded
//   pend  - pending-request register, observation only
interface priority_encoder_4to2_if;
  logic       e;
  logic [3:0] i;
  logic       ack;
  logic [1:0] y;
  logic       valid;
  logic       multi;
  logic [3:0] pend;

  modport master (
    output e, i, ack,
    input  y, valid, multi, pend
  );

  modport slave (
    input  e, i, ack,
    output y, valid, multi, pend
  );
endinterface

// File: rtl/priority_encoder_4to2.sv
// priority_encoder_4to2
// Registered 4-to-2 priority encoder with sticky request capture. Requests
// seen on i while e=1 are latched into a pending register; a two-state FSM
// grants one pending request at a time (highest priority first) and
// releases it when the consumer acknowledges.
//
// Parameters:
//   HIGH_FIRST - 1: i[3] has highest priority; 0: i[0] has highest priority.
// Ports:
//   clk       - rising-edge clock
//   rst       - synchronous active-high reset
//   bus       - request/grant interface (slave side)
//   fsm_state - current FSM state for observation (0 = IDLE, 1 = HOLD)
module priority_encoder_4to2 #(
  parameter int HIGH_FIRST = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  priority_encoder_4to2_if.slave  bus,
  output logic                    fsm_state
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t     state;
  logic [3:0] pend_q;
  logic [1:0] y_q;
  logic       valid_q;
  logic       multi_q;
  logic [3:0] clr;
  logic [3:0] set;

  // Index of the winning request bit according to HIGH_FIRST. The loop
  // direction makes the last matching bit the winner.
  function automatic logic [1:0] prio_index(input logic [3:0] req);
    logic [1:0] idx;
    idx = 2'd0;
    if (HIGH_FIRST != 0) begin
      for (int k = 0; k < 4; k++) begin
        if (req[k]) idx = 2'(k);
      end
    end else begin
      for (int k = 3; k >= 0; k--) begin
        if (req[k]) idx = 2'(k);
      end
    end
    return idx;
  endfunction

  // Clearing the lowest set bit leaves something only if two or more
  // bits were set.
  function automatic logic more_than_one(input logic [3:0] req);
    return (req & (req - 4'd1)) != 4'd0;
  endfunction

  always_comb begin
    clr = 4'b0000;
    if (valid_q && bus.ack) clr[y_q] = 1'b1;
  end

  assign set = bus.e ? bus.i : 4'b0000;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      pend_q  <= 4'b0000;
      y_q     <= 2'b00;
      valid_q <= 1'b0;
      multi_q <= 1'b0;
    end else begin
      // Set is OR-ed after the clear so a same-cycle re-request survives.
      pend_q <= (pend_q & ~clr) | set;
      case (state)
        IDLE: begin
          // Arbitrate on the registered pend, never on the live i.
          if (pend_q != 4'b0000) begin
            y_q     <= prio_index(pend_q);
            multi_q <= more_than_one(pend_q);
            valid_q <= 1'b1;
            state   <= HOLD;
          end
        end
        HOLD: begin
          // y and multi keep their values after the grant is released.
          if (bus.ack) begin
            valid_q <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.y     = y_q;
  assign bus.valid = valid_q;
  assign bus.multi = multi_q;
  assign bus.pend  = pend_q;
  assign fsm_state = (state == HOLD);

endmodule

// File: tb/tb_priority_encoder_4to2.sv
// Testbench for priority_encoder_4to2. Two instances (HIGH_FIRST=1 and
// HIGH_FIRST=0) see identical stimulus; both are compared every cycle with
// a behavioural model, and directed steps additionally check literal values.
module tb_priority_encoder_4to2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  priority_encoder_4to2_if bus_hi ();
  priority_encoder_4to2_if bus_lo ();
  logic state_hi;
  logic state_lo;

  assign bus_lo.e   = bus_hi.e;
  assign bus_lo.i   = bus_hi.i;
  assign bus_lo.ack = bus_hi.ack;

  priority_encoder_4to2 #(.HIGH_FIRST(1)) dut_hi (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus_hi.slave),
    .fsm_state (state_hi)
  );

  priority_encoder_4to2 #(.HIGH_FIRST(0)) dut_lo (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus_lo.slave),
    .fsm_state (state_lo)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  // Per instance: set of pending requests, plus the current grant record.
  logic [3:0] m_pend  [2];
  logic       m_live  [2];
  logic [1:0] m_y     [2];
  logic       m_multi [2];

  // Priority order as an explicit list: instance 0 scans 3,2,1,0; instance 1
  // scans 0,1,2,3. The first pending entry in the list wins.
  function automatic logic [1:0] model_pick(input int d, input logic [3:0] p);
    int order [4];
    for (int k = 0; k < 4; k++) order[k] = (d == 0) ? (3 - k) : k;
    for (int k = 0; k < 4; k++) begin
      if (p[order[k]]) return 2'(order[k]);
    end
    return 2'd0;
  endfunction

  task automatic model_edge(input logic r, input logic en, input logic [3:0] req,
                            input logic a);
    for (int d = 0; d < 2; d++) begin
      if (r) begin
        m_pend[d] = 4'b0000; m_live[d] = 1'b0; m_y[d] = 2'b00; m_multi[d] = 1'b0;
      end else begin
        logic [3:0] nxt;
        nxt = m_pend[d];
        if (m_live[d] && a) nxt[m_y[d]] = 1'b0;   // serviced request leaves
        if (en) nxt = nxt | req;                   // new requests always join
        if (m_live[d]) begin
          if (a) m_live[d] = 1'b0;
        end else if (m_pend[d] != 4'b0000) begin
          m_y[d]     = model_pick(d, m_pend[d]);
          m_multi[d] = ($countones(m_pend[d]) > 1);
          m_live[d]  = 1'b1;
        end
        m_pend[d] = nxt;
      end
    end
  endtask

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    check("hi_y",     {2'b00, bus_hi.y},     {2'b00, m_y[0]});
    check("hi_valid", {3'b000, bus_hi.valid}, {3'b000, m_live[0]});
    check("hi_multi", {3'b000, bus_hi.multi}, {3'b000, m_multi[0]});
    check("hi_pend",  bus_hi.pend,           m_pend[0]);
    check("hi_state", {3'b000, state_hi},     {3'b000, m_live[0]});
    check("lo_y",     {2'b00, bus_lo.y},     {2'b00, m_y[1]});
    check("lo_valid", {3'b000, bus_lo.valid}, {3'b000, m_live[1]});
    check("lo_multi", {3'b000, bus_lo.multi}, {3'b000, m_multi[1]});
    check("lo_pend",  bus_lo.pend,           m_pend[1]);
    check("lo_state", {3'b000, state_lo},     {3'b000, m_live[1]});
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic r, input logic en, input logic [3:0] req,
                      input logic a);
    rst = r; bus_hi.e = en; bus_hi.i = req; bus_hi.ack = a;
    @(posedge clk);
    model_edge(r, en, req, a);
    #1;
    check_model();
  endtask

  logic [1:0] exp_q   [$];
  logic [1:0] obs_q   [$];
  logic       exp_m_q [$];
  logic       obs_m_q [$];

  task automatic compare_grants(input string tag);
    check({tag, "_count"}, 4'(obs_q.size()), 4'(exp_q.size()));
    for (int k = 0; k < exp_q.size(); k++) begin
      if (k < obs_q.size()) begin
        check({tag, "_y"},     {2'b00, obs_q[k]},    {2'b00, exp_q[k]});
        check({tag, "_multi"}, {3'b000, obs_m_q[k]}, {3'b000, exp_m_q[k]});
      end
    end
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    for (int d = 0; d < 2; d++) begin
      m_pend[d] = 4'b0000; m_live[d] = 1'b0; m_y[d] = 2'b00; m_multi[d] = 1'b0;
    end
    bus_hi.e = 1'b0; bus_hi.i = 4'b0000; bus_hi.ack = 1'b0;
    @(negedge clk);

    // Reset with every input active.
    for (int k = 0; k < 2; k++) begin
      step(1'b1, 1'b1, 4'b1111, 1'b1);
      check("rst_y",     {2'b00, bus_hi.y},      4'h0);
      check("rst_valid", {3'b000, bus_hi.valid}, 4'h0);
      check("rst_multi", {3'b000, bus_hi.multi}, 4'h0);
      check("rst_pend",  bus_hi.pend,            4'h0);
    end

    // Single request.
    step(1'b0, 1'b1, 4'b0100, 1'b0);
    check("single_pend",  bus_hi.pend,            4'b0100);
    check("single_v0",    {3'b000, bus_hi.valid}, 4'h0);
    step(1'b0, 1'b0, 4'b0000, 1'b0);
    check("single_valid", {3'b000, bus_hi.valid}, 4'h1);
    check("single_y",     {2'b00, bus_hi.y},      4'h2);
    check("single_multi", {3'b000, bus_hi.multi}, 4'h0);
    step(1'b0, 1'b0, 4'b0000, 1'b1);
    check("single_done",  {3'b000, bus_hi.valid}, 4'h0);
    check("single_clr",   bus_hi.pend,            4'h0);

    // Multiple requests with ack held high: record grant sequences.
    step(1'b0, 1'b1, 4'b1011, 1'b1);
    obs_q.delete(); obs_m_q.delete();
    begin
      logic [1:0] lo_y [$];
      logic       lo_m [$];
      int         gap_ok;
      logic       prev_valid;
      gap_ok = 1; prev_valid = 1'b0;
      for (int k = 0; k < 8; k++) begin
        step(1'b0, 1'b0, 4'b0000, 1'b1);
        if (bus_hi.valid) begin
          obs_q.push_back(bus_hi.y); obs_m_q.push_back(bus_hi.multi);
          if (prev_valid) gap_ok = 0;
        end
        prev_valid = bus_hi.valid;
        if (bus_lo.valid) begin
          lo_y.push_back(bus_lo.y); lo_m.push_back(bus_lo.multi);
        end
      end
      check("multi_gap", 4'(gap_ok), 4'h1);
      exp_q = '{2'd3, 2'd1, 2'd0}; exp_m_q = '{1'b1, 1'b1, 1'b0};
      compare_grants("multi_hi");
      obs_q = lo_y; obs_m_q = lo_m;
      exp_q = '{2'd0, 2'd1, 2'd3}; exp_m_q = '{1'b1, 1'b1, 1'b0};
      compare_grants("multi_lo");
    end

    // Enable low blocks capture.
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 1'b0, 4'b1111, 1'b0);
      check("en_low_pend",  bus_hi.pend,            4'h0);
      check("en_low_valid", {3'b000, bus_hi.valid}, 4'h0);
    end
    // A grant raised earlier completes with e=0.
    step(1'b0, 1'b1, 4'b0010, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b0, 4'b1111, 1'b0);
      check("en_low_hold_y", {2'b00, bus_hi.y},      4'h1);
      check("en_low_hold_v", {3'b000, bus_hi.valid}, 4'h1);
      check("en_low_hold_p", bus_hi.pend,            4'b0010);
    end
    step(1'b0, 1'b0, 4'b1111, 1'b1);
    check("en_low_ack_v", {3'b000, bus_hi.valid}, 4'h0);
    check("en_low_ack_p", bus_hi.pend,            4'h0);

    // Set beats clear.
    step(1'b0, 1'b1, 4'b0100, 1'b0);
    step(1'b0, 1'b0, 4'b0000, 1'b0);
    check("sbc_live_y", {2'b00, bus_hi.y}, 4'h2);
    step(1'b0, 1'b1, 4'b0100, 1'b1);
    check("sbc_pend",   bus_hi.pend,            4'b0100);
    check("sbc_gap",    {3'b000, bus_hi.valid}, 4'h0);
    step(1'b0, 1'b0, 4'b0000, 1'b0);
    check("sbc_regrant_v", {3'b000, bus_hi.valid}, 4'h1);
    check("sbc_regrant_y", {2'b00, bus_hi.y},      4'h2);
    step(1'b0, 1'b0, 4'b0000, 1'b1);
    step(1'b0, 1'b0, 4'b0000, 1'b0);

    // Reset mid-grant.
    step(1'b0, 1'b1, 4'b1010, 1'b0);
    step(1'b0, 1'b0, 4'b0000, 1'b0);
    check("mid_y",    {2'b00, bus_hi.y}, 4'h3);
    check("mid_pend", bus_hi.pend,       4'b1010);
    step(1'b1, 1'b1, 4'b0000, 1'b0);
    check("mid_rst_y",     {2'b00, bus_hi.y},      4'h0);
    check("mid_rst_valid", {3'b000, bus_hi.valid}, 4'h0);
    check("mid_rst_multi", {3'b000, bus_hi.multi}, 4'h0);
    check("mid_rst_pend",  bus_hi.pend,            4'h0);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b1, 4'b0000, 1'b1);
      check("mid_idle_valid", {3'b000, bus_hi.valid}, 4'h0);
    end

    // Random traffic against the model.
    for (int k = 0; k < 500; k++) begin
      logic r, en, a;
      logic [3:0] req;
      r   = ($urandom_range(0, 40) == 0);
      en  = ($urandom_range(0, 3) != 0);
      req = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 2) == 0) req = 4'b0000;
      a   = ($urandom_range(0, 1) == 1);
      step(r, en, req, a);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/priority_encoder_4to2.md
# priority_encoder_4to2

Registered 4-to-2 priority encoder with sticky request capture and a valid/ack handshake. It is the encode-side counterpart of the 2-to-4 decoder: it turns a set of request lines into a 2-bit index, one grant at a time, until every captured request has been serviced. It sits between discrete request sources and a consumer that takes one index per handshake.

## Interface

Parameters:
- HIGH_FIRST, default 1. When 1, i[3] has the highest priority. When 0, i[0] has the highest priority.

Ports:
- clk, input, 1: single clock. All state changes on the rising edge.
- rst, input, 1: reset, synchronous and active-high.
- e, input, 1: capture enable. Requests on i are latched only while e=1.
- i, input, 4: request lines. Sampled each cycle.
- ack, input, 1: consumer accepts the current grant. Meaningful only while valid=1.
- y, output, 2: encoded index of the granted request. Registered.
- valid, output, 1: y holds a live grant. Registered.
- multi, output, 1: other requests were still pending when the current grant was loaded. Registered.
- pend, output, 4: pending-request register, for observation.

## Operation

- Pending register update, every edge: pend <= (pend & ~clr) | (e ? i : 4'b0000).
  - clr = one-hot of y when valid=1 and ack=1; otherwise 0000.
  - A new request wins over a clear of the same bit, so a same-cycle re-request is not lost.
- State machine with two states, IDLE and HOLD.
- IDLE:
  - If registered pend != 0000: load y with the priority index of pend (per HIGH_FIRST).
  - Load multi = 1 if pend has two or more bits set, else 0.
  - Set valid=1 and go to HOLD.
  - The arbitration uses the registered pend, not the live i.
- HOLD:
  - y, multi and valid stay stable until ack=1.
  - On ack: valid <= 0, clear pend[y] (subject to the set-wins rule), go to IDLE.
  - y and multi keep their last values while valid=0.
- ack while valid=0 is ignored and has no side effects.
- e=0 blocks only new captures. Existing pend bits and an in-flight grant continue normally.
- Requests already in pend are never dropped except by their own ack or by rst.
- Encoding (HIGH_FIRST=1): 1xxx -> 11, 01xx -> 10, 001x -> 01, 0001 -> 00. With HIGH_FIRST=0 the priority order is mirrored (bit 0 first).

## Timing

- Reset values: y=00, valid=0, multi=0, pend=0000, state=IDLE.
- rst overrides e, i and ack in the same edge.
- Reset mid-grant discards the grant and all pending bits. No grant appears until a new request is captured.
- Latency: request present on i with e=1 before edge N -> pend bit set after edge N -> valid=1 and y set after edge N+1, provided the FSM was in IDLE.
- Handshake:
  - The grant completes at the edge where valid=1 and ack=1.
  - valid is low for at least one full cycle between consecutive grants.
  - Maximum throughput is one grant per two cycles.
- Continuous ack=1: each grant lasts exactly one cycle with valid high, followed by one cycle low.
- Simultaneous capture of the granted bit and its ack: the bit stays pending and is re-granted two edges later (after the IDLE cycle).
- A higher-priority request arriving during HOLD does not pre-empt the grant. It is served at the next IDLE.

## Test plan

- Reset: rst=1 for 2 cycles with e=1, i=1111, ack=1 -> y=00, valid=0, multi=0, pend=0000 after each edge.
- Single request: e=1, i=0100 for one cycle -> pend=0100 after edge 1. Then valid=1, y=10, multi=0 after edge 2. ack=1 for one cycle -> valid=0, pend=0000.
- Multiple requests: i=1011 for one cycle, ack held at 1.
  - HIGH_FIRST=1: grants y=11, 01, 00 with multi=1, 1, 0, and valid low for one cycle between grants.
  - HIGH_FIRST=0: order is 00, 01, 11.
- Enable low: e=0, i=1111 for 5 cycles -> pend=0000 and valid=0 throughout. Then a grant raised earlier (pend=0010) completes normally on ack.
- Set beats clear: grant y=10 live, ack=1 and i=0100 with e=1 in the same cycle -> pend=0100 retained, valid=0 for one cycle, then valid=1, y=10 again.
- Reset mid-operation: valid=1, y=11, pend=1010, rst=1 for one cycle -> all outputs return to reset values at that edge. No grant while i=0000.
